// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared types and default parameter values for the PLL lock supervisor.
//   pll_state_e : supervisor FSM state, also exported on state_dbg
//   *_DEF       : default values for the supervisor parameters
// -----------------------------------------------------------------------------
package pll_sup_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2,
        LOST      = 2'd3
    } pll_state_e;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int LOCK_HOLD_DEF   = 1024;
    localparam int HB_DIV_BITS_DEF = 25;
    localparam int LOSS_CNT_W_DEF  = 8;

endpackage

// File: rtl/pll_lock_supervisor_lock_sync.sv
// -----------------------------------------------------------------------------
// lock_sync
// SYNC_STAGES-deep single-bit synchronizer, async active-low reset to 0.
// Ports:
//   clk     in   destination clock
//   resetn  in   asynchronous active-low reset
//   d       in   asynchronous input
//   q       out  synchronized output (last flop of the chain)
// -----------------------------------------------------------------------------
module lock_sync
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Watches the PLL LOCK flag and holds the fabric in reset until lock has been
// stable for LOCK_HOLD cycles. Also drives a heartbeat LED and counts lock
// losses seen while running.
// Optional build macro: PLL_SUP_FAULT_BLINK_EN -- after any lock loss in RUN,
// the LED blinks fast while waiting for / holding lock again.
// Ports:
//   clk         in   PLL output clock, sole clock
//   resetn      in   asynchronous active-low reset
//   pll_lock    in   PLL LOCK flag, asynchronous to clk
//   sys_rst_n   out  fabric reset, active-low, synchronous deassert
//   led         out  heartbeat LED
//   loss_count  out  saturating count of RUN-state lock losses
//   state_dbg   out  current FSM state encoding
// -----------------------------------------------------------------------------
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int LOCK_HOLD   = LOCK_HOLD_DEF,
    parameter int HB_DIV_BITS = HB_DIV_BITS_DEF,
    parameter int LOSS_CNT_W  = LOSS_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pll_lock,
    output logic                  sys_rst_n,
    output logic                  led,
    output logic [LOSS_CNT_W-1:0] loss_count,
    output logic [1:0]            state_dbg
);

    localparam int HOLD_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(LOCK_HOLD - 1);

    logic                   lock_s;
    pll_state_e             state;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [HB_DIV_BITS-1:0] hb_cnt;

    lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pll_lock),
        .q      (lock_s)
    );

    // sys_rst_n and the heartbeat are updated in the same branch that picks
    // the next state, so both change on exactly the edge the state does.
    // The heartbeat only counts while staying in RUN and is zeroed on any
    // exit, so the LED is dark whenever the fabric is held in reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= WAIT_LOCK;
            hold_cnt   <= '0;
            sys_rst_n  <= 1'b0;
            loss_count <= '0;
            hb_cnt     <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    // a captured glitch restarts the whole hold time
                    if (!lock_s) begin
                        state    <= WAIT_LOCK;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_TERM) begin
                        state     <= RUN;
                        sys_rst_n <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state     <= LOST;
                        sys_rst_n <= 1'b0;
                        hb_cnt    <= '0;
                        if (loss_count != '1) begin
                            loss_count <= loss_count + 1'b1;
                        end
                    end else begin
                        hb_cnt <= hb_cnt + 1'b1;
                    end
                end
                LOST: begin
                    // extra cycle guarantees a reset pulse of at least two cycles
                    state <= WAIT_LOCK;
                end
                default: begin
                    state     <= WAIT_LOCK;
                    sys_rst_n <= 1'b0;
                    hb_cnt    <= '0;
                end
            endcase
        end
    end

    assign state_dbg = state;

`ifdef PLL_SUP_FAULT_BLINK_EN
    logic                   fault;
    logic [HB_DIV_BITS-1:0] fast_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fault    <= 1'b0;
            fast_cnt <= '0;
        end else begin
            fast_cnt <= fast_cnt + 1'b1;
            if (state == RUN && !lock_s) begin
                fault <= 1'b1;
            end
        end
    end

    assign led = (fault && (state == WAIT_LOCK || state == HOLD))
                 ? fast_cnt[HB_DIV_BITS-4]
                 : hb_cnt[HB_DIV_BITS-1];
`else
    assign led = hb_cnt[HB_DIV_BITS-1];
`endif

endmodule
